lzw_decode_stream: RTL

Parametrised streaming LZW decompressor: accepts fixed-width LZW codes on an AXI-Stream-style input and emits the decoded byte stream on an AXI-Stream-style output with full backpressure. It replaces the fixed 16-bit, 8-entry-per-row decoder in the LZW datapath.

- Dictionary is a prefix/suffix table with configurable depth and code width.
- Supports CLEAR codes, the KwKwK case, dictionary-full freeze and error flagging.

---
 rtl/lzw_decode_stream.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lzw_decode_stream.sv
// Streaming LZW decompressor.
// Fixed-width codes come in on an AXI-Stream-style port and decoded bytes go
// out on a second one, with full backpressure. The dictionary is a
// prefix/suffix table. Each string is walked from its last byte back to its
// first, pushed onto a reversal stack, and popped out in forward order.
module lzw_decode_stream #(
    parameter int CODE_W     = 12,
    parameter int DICT_DEPTH = 2**CODE_W,
    parameter int MAX_STR    = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CODE_W-1:0] s_code,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              o_dict_full,
    output logic              o_err
);

    // The final byte of a walk goes straight to m_data, so the stack only
    // ever holds MAX_STR-1 bytes. A pointer of clog2(MAX_STR) bits covers that.
    localparam int SP_W = (MAX_STR > 2) ? $clog2(MAX_STR) : 1;

    localparam logic [CODE_W:0] CLEAR_CODE = (CODE_W+1)'(256);
    localparam logic [CODE_W:0] FIRST_DYN  = (CODE_W+1)'(257);
    localparam logic [CODE_W:0] DEPTH_W    = (CODE_W+1)'(DICT_DEPTH);
    localparam logic [SP_W-1:0] SP_LIMIT   = SP_W'(MAX_STR - 1);

    typedef enum logic [1:0] {IDLE, WALK, EMIT} state_t;

    state_t            state;
    logic [CODE_W-1:0] code_reg;    // code being decoded
    logic [CODE_W-1:0] cur;         // walk cursor
    logic [CODE_W-1:0] prev_code;
    logic              prev_valid;
    logic [7:0]        first_byte;  // first byte of the previous string
    logic              last_pkt;
    logic              kwk_push;    // KwKwK: extra byte still to be pushed
    logic              pend_valid;  // a dictionary entry is owed at walk end
    logic [CODE_W:0]   next_code;
    logic [SP_W-1:0]   sp;

    logic [CODE_W-1:0] prefix_tab [0:DICT_DEPTH-1];
    logic [7:0]        suffix_tab [0:DICT_DEPTH-1];
    logic [7:0]        stack_mem  [0:MAX_STR-1];

    logic [CODE_W:0]   code_ext;
    logic [CODE_W:0]   cur_ext;
    logic              walk_final;
    logic [7:0]        push_byte;
    logic              walk_push;
    logic              dict_we;
    logic [SP_W-1:0]   sp_top;

    assign code_ext   = {1'b0, s_code};
    assign cur_ext    = {1'b0, cur};
    // The walk ends on a literal, unless the KwKwK byte has not been pushed yet.
    assign walk_final = !kwk_push && (cur_ext < FIRST_DYN);
    assign push_byte  = kwk_push ? first_byte : suffix_tab[cur];
    assign walk_push  = (state == WALK) && !walk_final && (sp != SP_LIMIT);
    assign dict_we    = (state == WALK) && walk_final && pend_valid && (next_code < DEPTH_W);
    assign sp_top     = sp - 1'b1;

    // Dictionary write: the owed entry (prev, first byte of this string) lands at next_code.
    // NOTE: the tables and the stack are plain RAM with no reset. They are only
    // read at locations that were written after the last reset.
    always_ff @(posedge i_clk) begin
        if (dict_we) begin
            prefix_tab[next_code[CODE_W-1:0]] <= prev_code;
            suffix_tab[next_code[CODE_W-1:0]] <= cur[7:0];
        end
    end

    // Reversal stack push: one byte per WALK cycle, last byte of the string first.
    always_ff @(posedge i_clk) begin
        if (walk_push) begin
            stack_mem[sp] <= push_byte;
        end
    end

    // Control FSM: classify the incoming code, walk the string, then emit bytes under backpressure.
    // NOTE: every register in this process uses non-blocking assignment. All
    // branches then see the values from before the edge, as the hardware does.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            code_reg    <= '0;
            cur         <= '0;
            prev_code   <= '0;
            prev_valid  <= 1'b0;
            first_byte  <= '0;
            last_pkt    <= 1'b0;
            kwk_push    <= 1'b0;
            pend_valid  <= 1'b0;
            next_code   <= FIRST_DYN;
            sp          <= '0;
            s_ready     <= 1'b1;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            o_dict_full <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        code_reg <= s_code;
                        last_pkt <= s_last;
                        sp       <= '0;
                        kwk_push <= 1'b0;
                        if (code_ext == CLEAR_CODE) begin
                            next_code   <= FIRST_DYN;
                            prev_valid  <= 1'b0;
                            o_dict_full <= 1'b0;
                        end else if (!prev_valid) begin
                            if (code_ext < CLEAR_CODE) begin
                                cur        <= s_code;
                                pend_valid <= 1'b0;
                                s_ready    <= 1'b0;
                                state      <= WALK;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end else if (code_ext < next_code) begin
                            cur        <= s_code;
                            pend_valid <= 1'b1;
                            s_ready    <= 1'b0;
                            state      <= WALK;
                        end else if (code_ext == next_code) begin
                            // KwKwK: the string is prev followed by prev's first byte.
                            cur        <= prev_code;
                            kwk_push   <= 1'b1;
                            pend_valid <= 1'b1;
                            s_ready    <= 1'b0;
                            state      <= WALK;
                        end else begin
                            o_err      <= 1'b1;
                            prev_valid <= 1'b0;
                        end
                    end
                end

                WALK: begin
                    if (walk_final) begin
                        if (dict_we) begin
                            next_code <= next_code + 1'b1;
                            if ((next_code + 1'b1) == DEPTH_W) begin
                                o_dict_full <= 1'b1;
                            end
                        end
                        prev_code  <= code_reg;
                        prev_valid <= 1'b1;
                        first_byte <= cur[7:0];
                        m_data     <= cur[7:0];
                        m_last     <= last_pkt && (sp == '0);
                        m_valid    <= 1'b1;
                        state      <= EMIT;
                    end else if (sp == SP_LIMIT) begin
                        // The string is longer than the stack can hold: drop it.
                        o_err      <= 1'b1;
                        sp         <= '0;
                        prev_valid <= 1'b0;
                        s_ready    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        sp       <= sp + 1'b1;
                        kwk_push <= 1'b0;
                        if (!kwk_push) begin
                            cur <= prefix_tab[cur];
                        end
                    end
                end

                EMIT: begin
                    if (m_ready) begin
                        if (sp == '0) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            m_data <= stack_mem[sp_top];
                            m_last <= last_pkt && (sp_top == '0);
                            sp     <= sp_top;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
